// File: rtl/bpsk_frame_tx_pkg.sv
// Shared state type and helpers for the BPSK/DBPSK frame transmitter.
package bpsk_pkg;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} tx_state_t;

    function automatic int unsigned clk_div_count(input int unsigned clock_in,
                                                  input int unsigned clock_carrier);
        return clock_in / (2 * clock_carrier);
    endfunction

    // Preamble symbols alternate 1,0,1,0,... starting with a 1.
    function automatic logic preamble_bit(input int unsigned idx);
        return (idx % 2) == 0;
    endfunction

endpackage

// File: rtl/bpsk_frame_tx_if.sv
// Word handshake between the byte source and the BPSK frame transmitter.
interface bpsk_frame_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output data_in, data_valid, input data_ready);
    modport slave  (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/bpsk_carrier_gen.sv
// Free-running square-wave carrier with tick and symbol-boundary decodes.
module bpsk_carrier_gen
    import bpsk_pkg::*;
#(
    parameter int unsigned CLK_DIV_COUNT = 2,
    parameter int unsigned HALF_COUNT    = 2
) (
    input  logic clk,
    input  logic n_rst,
    output logic tick,
    output logic boundary,
    output logic carrier
);
    localparam int unsigned CW = ($clog2(CLK_DIV_COUNT) > 0) ? $clog2(CLK_DIV_COUNT) : 1;
    localparam int unsigned HW = ($clog2(HALF_COUNT) > 0) ? $clog2(HALF_COUNT) : 1;

    generate
        if (CLK_DIV_COUNT < 2) begin : g_bad_div
            $error("bpsk_carrier_gen: CLK_DIV_COUNT must be at least 2");
        end
    endgenerate

    logic [CW-1:0] clk_counter;
    logic [HW-1:0] half_cnt;
    logic          carrier_reg;

    assign tick     = clk_counter == CW'(CLK_DIV_COUNT - 1);
    assign boundary = tick && (half_cnt == HW'(HALF_COUNT - 1));
    assign carrier  = carrier_reg;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            clk_counter <= '0;
            half_cnt    <= '0;
            carrier_reg <= 1'b0;
        end else if (tick) begin
            clk_counter <= '0;
            carrier_reg <= ~carrier_reg;
            half_cnt    <= (half_cnt == HW'(HALF_COUNT - 1)) ? '0 : half_cnt + 1'b1;
        end else begin
            clk_counter <= clk_counter + 1'b1;
        end
    end
endmodule

// File: rtl/bpsk_frame_tx.sv
// BPSK/DBPSK frame transmitter: buffered word stream, optional preamble, carrier mapper.
module bpsk_frame_tx
    import bpsk_pkg::*;
#(
    parameter int unsigned CLOCK_IN      = 20_000_000,
    parameter int unsigned CLOCK_CARRIER = 64_000,
    parameter int unsigned CYCLE_COUNT   = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PREAMBLE_LEN  = 8,
    parameter bit          MSB_FIRST     = 1'b0
) (
    input  logic            clk,
    input  logic            n_rst,
    bpsk_frame_tx_if.slave  bus,
    input  logic            diff_mode,
    output logic            wave_out,
    output logic            tx_active,
    output logic            sym_strobe,
    output logic            data_finish
);
    localparam int unsigned CLK_DIV_COUNT = clk_div_count(CLOCK_IN, CLOCK_CARRIER);
    localparam int unsigned HALF_COUNT    = 2 * CYCLE_COUNT;
    localparam int unsigned BW = ($clog2(DATA_WIDTH) > 0) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned PW = ($clog2(PREAMBLE_LEN) > 0) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0] LAST_PRE = PW'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    tx_state_t             state, state_n;
    logic [DATA_WIDTH-1:0] hold, hold_n, shift, shift_n;
    logic                  hold_full, hold_full_n;
    logic                  mode_r, mode_n;
    logic                  phase, phase_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [PW-1:0]         pre_cnt, pre_cnt_n;
    logic                  sym_bit, new_sym;
    logic                  handshake, boundary, carrier, carrier_tick_unused;

    bpsk_carrier_gen #(
        .CLK_DIV_COUNT (CLK_DIV_COUNT),
        .HALF_COUNT    (HALF_COUNT)
    ) u_carrier (
        .clk      (clk),
        .n_rst    (n_rst),
        .tick     (carrier_tick_unused),
        .boundary (boundary),
        .carrier  (carrier)
    );

    function automatic logic word_bit(input logic [DATA_WIDTH-1:0] w, input logic [BW-1:0] idx);
        return MSB_FIRST ? w[LAST_BIT - idx] : w[idx];
    endfunction

    assign bus.data_ready = n_rst && !hold_full;
    assign handshake      = bus.data_valid && bus.data_ready;
    assign wave_out       = carrier ^ phase;
    assign tx_active      = state != IDLE;
    assign sym_strobe     = new_sym;

    always_comb begin
        state_n     = state;
        hold_n      = hold;
        hold_full_n = hold_full;
        shift_n     = shift;
        mode_n      = mode_r;
        phase_n     = phase;
        bit_cnt_n   = bit_cnt;
        pre_cnt_n   = pre_cnt;
        sym_bit     = 1'b0;
        new_sym     = 1'b0;
        data_finish = 1'b0;

        // hold can only be loaded while empty and only drained while full, so these never collide
        if (handshake) begin
            hold_n      = bus.data_in;
            hold_full_n = 1'b1;
        end

        if (boundary) begin
            case (state)
                IDLE: if (hold_full) begin
                    shift_n     = hold;
                    hold_full_n = 1'b0;
                    mode_n      = diff_mode;
                    bit_cnt_n   = '0;
                    pre_cnt_n   = '0;
                    new_sym     = 1'b1;
                    if (PREAMBLE_LEN > 0) begin
                        state_n = PREAMBLE;
                        sym_bit = preamble_bit(0);
                    end else begin
                        state_n = DATA;
                        sym_bit = word_bit(hold, '0);
                    end
                end
                PREAMBLE: begin
                    new_sym = 1'b1;
                    if (pre_cnt == LAST_PRE) begin
                        state_n = DATA;
                        sym_bit = word_bit(shift, '0);
                    end else begin
                        pre_cnt_n = pre_cnt + 1'b1;
                        sym_bit   = preamble_bit(32'(pre_cnt) + 32'd1);
                    end
                end
                DATA: if (bit_cnt == LAST_BIT) begin
                    data_finish = 1'b1;
                    if (hold_full) begin
                        shift_n     = hold;
                        hold_full_n = 1'b0;
                        bit_cnt_n   = '0;
                        new_sym     = 1'b1;
                        sym_bit     = word_bit(hold, '0);
                    end else begin
                        state_n = IDLE;
                        phase_n = 1'b0;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    new_sym   = 1'b1;
                    sym_bit   = word_bit(shift, bit_cnt + 1'b1);
                end
                default: state_n = IDLE;
            endcase
        end

        // phase is 0 throughout IDLE, which doubles as the zeroed differential reference at frame start
        if (new_sym) phase_n = (mode_n & phase) ^ sym_bit;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            mode_r    <= 1'b0;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
        end else begin
            state     <= state_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            shift     <= shift_n;
            mode_r    <= mode_n;
            phase     <= phase_n;
            bit_cnt   <= bit_cnt_n;
            pre_cnt   <= pre_cnt_n;
        end
    end
endmodule

// File: tb/tb_bpsk_frame_tx.sv
// Self-checking bench for bpsk_frame_tx: directed table, corner sequences, randomized frames.
module tb_bpsk_frame_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst = 1'b0;
    logic diff_mode = 1'b0;
    logic wave0, act0, strb0, fin0;
    logic wave1, act1, strb1, fin1;

    bpsk_frame_tx_if #(.DATA_WIDTH(8)) bus0 ();
    bpsk_frame_tx_if #(.DATA_WIDTH(8)) bus1 ();

    bpsk_frame_tx #(
        .CLOCK_IN(16), .CLOCK_CARRIER(2), .CYCLE_COUNT(1),
        .DATA_WIDTH(8), .PREAMBLE_LEN(4), .MSB_FIRST(1'b0)
    ) dut0 (
        .clk(clk), .n_rst(n_rst), .bus(bus0), .diff_mode(diff_mode),
        .wave_out(wave0), .tx_active(act0), .sym_strobe(strb0), .data_finish(fin0)
    );

    bpsk_frame_tx #(
        .CLOCK_IN(16), .CLOCK_CARRIER(2), .CYCLE_COUNT(1),
        .DATA_WIDTH(8), .PREAMBLE_LEN(0), .MSB_FIRST(1'b1)
    ) dut1 (
        .clk(clk), .n_rst(n_rst), .bus(bus1), .diff_mode(diff_mode),
        .wave_out(wave1), .tx_active(act1), .sym_strobe(strb1), .data_finish(fin1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle count since reset release; the carrier is a pure function of it.
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (!n_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic carrier_model(input int unsigned c);
        return ((c / 4) % 2) != 0;
    endfunction

    bit          mon_en = 1'b0;
    bit          prev_strb0 = 1'b0, prev_strb1 = 1'b0;
    bit          cap0[$], cap1[$];
    int unsigned strb_cyc0[$], fin_cyc0[$];
    int unsigned fin_cnt1 = 0, act_cycles = 0, idle_err = 0;

    always @(negedge clk) begin
        logic ph0, ph1;
        if (mon_en) begin
            ph0 = wave0 ^ carrier_model(cyc);
            ph1 = wave1 ^ carrier_model(cyc);
            if (prev_strb0) cap0.push_back(ph0);
            if (prev_strb1) cap1.push_back(ph1);
            if (strb0) strb_cyc0.push_back(cyc);
            if (fin0) fin_cyc0.push_back(cyc);
            if (fin1) fin_cnt1++;
            if (act0) act_cycles++;
            if (!act0 && ph0) idle_err++;
            prev_strb0 = strb0;
            prev_strb1 = strb1;
        end
    end

    function automatic void clear_mon();
        cap0.delete(); cap1.delete(); strb_cyc0.delete(); fin_cyc0.delete();
        fin_cnt1 = 0; act_cycles = 0; idle_err = 0;
    endfunction

    // Reference: symbol bit list from the frame rules, then map to phases.
    bit exp_q[$];
    function automatic void build_expected(input logic [7:0] words[$], input bit diff,
                                           input int unsigned pl, input bit msb);
        bit bits[$];
        bit ph = 1'b0;
        exp_q.delete();
        for (int unsigned i = 0; i < pl; i++) bits.push_back((i % 2) == 0);
        foreach (words[k]) for (int j = 0; j < 8; j++) bits.push_back(msb ? words[k][7-j] : words[k][j]);
        foreach (bits[i]) begin
            ph = diff ? (ph ^ bits[i]) : bits[i];
            exp_q.push_back(ph);
        end
    endfunction

    task automatic send_word(input int sel, input logic [7:0] w, output int unsigned hs_cyc);
        int  n = 0;
        bit  ok = 1'b0;
        bit  rdy;
        if (sel == 0) begin bus0.data_in = w; bus0.data_valid = 1'b1; end
        else          begin bus1.data_in = w; bus1.data_valid = 1'b1; end
        hs_cyc = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            rdy = (sel == 0) ? bus0.data_ready : bus1.data_ready;
            hs_cyc = cyc;
            @(posedge clk); #1;
            n++;
            if (rdy) ok = 1'b1;
        end
        bus0.data_valid = 1'b0;
        bus1.data_valid = 1'b0;
        check("handshake_done", int'(ok), 1);
    endtask

    task automatic wait_frame(input int sel);
        int n = 0;
        while (((sel == 0) ? act0 : act1) == 1'b0 && n < 30) begin @(posedge clk); #1; n++; end
        n = 0;
        while (((sel == 0) ? act0 : act1) == 1'b1 && n < 600) begin @(posedge clk); #1; n++; end
        check("frame_ends", int'((sel == 0) ? act0 : act1), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic compare_frame0(input string tag, input int unsigned nfin);
        int bad_gap = 0;
        check({tag, "_nsym"}, cap0.size(), exp_q.size());
        foreach (exp_q[i]) check($sformatf("%s_phase%0d", tag, i),
                                 (i < cap0.size()) ? int'(cap0[i]) : -1, int'(exp_q[i]));
        check({tag, "_finish"}, fin_cyc0.size(), nfin);
        for (int i = 1; i < strb_cyc0.size(); i++) if (strb_cyc0[i] - strb_cyc0[i-1] != 8) bad_gap++;
        check({tag, "_gap"}, bad_gap, 0);
        check({tag, "_idle_phase"}, idle_err, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wave"}, int'(wave0), 0);
        check({tag, "_active"}, int'(act0), 0);
        check({tag, "_strobe"}, int'(strb0), 0);
        check({tag, "_finish"}, int'(fin0), 0);
        check({tag, "_ready"}, int'(bus0.data_ready), 0);
    endtask

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        bit          two;
        bit          diff;
        int unsigned nsym;
        bit [0:19]   ph;
        int unsigned nfin;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int unsigned hs, h;
        int          err, n;
        logic [7:0]  wq[$];

        vecs[0] = '{8'hA5, 8'h00, 1'b0, 1'b0, 12, 20'b1010_1010_0101_0000_0000, 1};
        vecs[1] = '{8'h01, 8'hFF, 1'b1, 1'b1, 20, 20'b1100_1111_1111_0101_0101, 2};
        vecs[2] = '{8'h3C, 8'h00, 1'b0, 1'b0, 12, 20'b1010_0011_1100_0000_0000, 1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b1, 12, 20'b1100_0000_0000_0000_0000, 1};

        bus0.data_in = '0; bus0.data_valid = 1'b0;
        bus1.data_in = '0; bus1.data_valid = 1'b0;

        // Reset state and idle carrier
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        n_rst = 1'b1;
        clear_mon();
        mon_en = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(bus0.data_ready), 1);
        err = 0;
        repeat (40) begin
            @(negedge clk);
            if (wave0 != carrier_model(cyc) || !bus0.data_ready) err++;
        end
        check("idle_carrier", err, 0);
        check("idle_inactive", act_cycles, 0);
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[v]) begin
            clear_mon();
            diff_mode = vecs[v].diff;
            send_word(0, vecs[v].w0, hs);
            if (vecs[v].two) send_word(0, vecs[v].w1, hs);
            wait_frame(0);
            check($sformatf("vec%0d_nsym", v), cap0.size(), vecs[v].nsym);
            for (int unsigned i = 0; i < vecs[v].nsym; i++)
                check($sformatf("vec%0d_phase%0d", v, i),
                      (i < cap0.size()) ? int'(cap0[i]) : -1, int'(vecs[v].ph[i]));
            check($sformatf("vec%0d_finish", v), fin_cyc0.size(), vecs[v].nfin);
            if (vecs[v].nfin == 2)
                check($sformatf("vec%0d_finish_spacing", v),
                      (fin_cyc0.size() == 2) ? int'(fin_cyc0[1] - fin_cyc0[0]) : -1, 64);
            check($sformatf("vec%0d_idle_phase", v), idle_err, 0);
        end

        // Handshake on a boundary cycle: start waits a full symbol
        clear_mon();
        diff_mode = 1'b0;
        n = 0;
        while ((cyc % 8) != 7 && n < 16) begin @(posedge clk); #1; n++; end
        h = cyc;
        bus0.data_in = 8'h96; bus0.data_valid = 1'b1;
        @(negedge clk);
        check("bnd_ready", int'(bus0.data_ready), 1);
        @(posedge clk); #1;
        bus0.data_valid = 1'b0;
        wait_frame(0);
        check("bnd_first_strobe", (strb_cyc0.size() > 0) ? int'(strb_cyc0[0] - h) : -1, 8);
        wq = '{8'h96};
        build_expected(wq, 1'b0, 4, 1'b0);
        compare_frame0("bnd", 1);

        // Reset in the middle of DATA with a second word held
        clear_mon();
        send_word(0, 8'h5A, hs);
        send_word(0, 8'hC3, hs);
        n = 0;
        while (strb_cyc0.size() < 6 && n < 200) begin @(posedge clk); #1; n++; end
        check("mid_active", int'(act0), 1);
        check("mid_held", int'(bus0.data_ready), 0);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        n_rst = 1'b1;
        clear_mon();
        repeat (100) begin @(posedge clk); #1; end
        check("midrst_no_tx", act_cycles, 0);
        check("midrst_no_finish", fin_cyc0.size(), 0);
        check("midrst_idle_phase", idle_err, 0);

        // MSB-first, no preamble
        clear_mon();
        send_word(1, 8'h80, hs);
        wait_frame(1);
        wq = '{8'h80};
        build_expected(wq, 1'b0, 0, 1'b1);
        check("msb_nsym", cap1.size(), exp_q.size());
        foreach (exp_q[i]) check($sformatf("msb_phase%0d", i),
                                 (i < cap1.size()) ? int'(cap1[i]) : -1, int'(exp_q[i]));
        check("msb_finish", fin_cnt1, 1);

        // Randomized frames against the reference model
        for (int f = 0; f < 12; f++) begin
            int unsigned nw;
            repeat ($urandom_range(0, 10)) begin @(posedge clk); #1; end
            clear_mon();
            nw = $urandom_range(1, 3);
            diff_mode = 1'($urandom_range(0, 1));
            wq.delete();
            for (int unsigned k = 0; k < nw; k++) wq.push_back(8'($urandom));
            build_expected(wq, diff_mode, 4, 1'b0);
            foreach (wq[k]) send_word(0, wq[k], hs);
            wait_frame(0);
            compare_frame0($sformatf("rnd%0d", f), nw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
